num_ram_arbiter: RTL and testbench

//  Shares the single-write/single-read number storage RAM between two write requesters
//  (A: ASCII number separator, B: result writeback) and two read requesters
//  (A: matrix loader, B: display/UART dump). Sequences RAM clear and blocks all access

---
 rtl/num_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_num_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/num_ram_arbiter.sv
// num_ram_arbiter: shares the single-write/single-read number RAM between two
// write requesters (A: ASCII separator, B: result writeback) and two read
// requesters (A: matrix loader, B: display/UART dump). Sequences the RAM clear
// sweep and blocks all access while it runs.
// Optional: define NUM_RAM_ARB_STATS_EN to add per-port conflict counters.

// Two-requester round-robin arbiter; index 0 = side A, 1 = side B.
module num_ram_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_b;   // 1 = side B wins the next conflict

  // Single request is granted straight through; a conflict goes to the pointer side
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = ptr_b ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  // Pointer only moves on a conflict, handing the next one to the loser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr_b <= 1'b0;
    else if (en && (&req))   ptr_b <= ~ptr_b;
  end
endmodule

module num_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  wa_req,
  input  logic [ADDR_WIDTH-1:0] wa_addr,
  input  logic [DATA_WIDTH-1:0] wa_data,
  output logic                  wa_gnt,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_gnt,
  input  logic                  ra_req,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic                  ra_gnt,
  output logic                  ra_valid,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic                  rb_req,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic                  rb_gnt,
  output logic                  rb_valid,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  ram_clear,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
`ifdef NUM_RAM_ARB_STATS_EN
  output logic [15:0]           wr_conflict_cnt,
  output logic [15:0]           rd_conflict_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);
  typedef enum logic {IDLE, CLEARING} state_t;

  // Sweep runs DEPTH+1 cycles: the ram_clear cycle plus one per RAM word
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic                  grant_en;
  logic [1:0][1:0]       port_req;   // [port: 0=write,1=read][side: 0=A,1=B]
  logic [1:0][1:0]       port_gnt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [1:0]            vld_pipe;   // read grant delayed one cycle, per side

  assign clear_busy = (state == CLEARING);
  // Grants are blocked in reset, during the sweep, and in the cycle clear is requested
  assign grant_en   = rst_n & ~clear_busy & ~clear_req;

  // Clear sequencer; a new clear_req restarts the sweep from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      ram_clear  <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      ram_clear  <= 1'b0;
      clear_done <= 1'b0;
      if (clear_req) begin
        state     <= CLEARING;
        clr_cnt   <= '0;
        ram_clear <= 1'b1;
      end else if (state == CLEARING) begin
        if (clr_cnt == CLR_LAST) begin
          state      <= IDLE;
          clr_cnt    <= '0;
          clear_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

  assign port_req[0] = {wb_req, wa_req};
  assign port_req[1] = {rb_req, ra_req};

  for (genvar p = 0; p < 2; p++) begin : g_port
    num_ram_rr u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (grant_en),
      .req   (port_req[p]),
      .gnt   (port_gnt[p])
    );
  end

  assign {wb_gnt, wa_gnt} = port_gnt[0];
  assign {rb_gnt, ra_gnt} = port_gnt[1];

  assign ram_wr_en   = |port_gnt[0];
  assign ram_wr_addr = port_gnt[0][1] ? wb_addr : wa_addr;
  assign ram_wr_data = port_gnt[0][1] ? wb_data : wa_data;

  // Read address follows the winner and otherwise holds the last granted address
  assign ram_rd_addr = (|port_gnt[1]) ? (port_gnt[1][1] ? rb_addr : ra_addr) : rd_addr_q;

  // Remember the last granted read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rd_addr_q <= '0;
    else if (|port_gnt[1])  rd_addr_q <= ram_rd_addr;
  end

  // Read valid tracks the one-cycle RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= port_gnt[1];
  end

  assign ra_valid = vld_pipe[0];
  assign rb_valid = vld_pipe[1];
  assign ra_data  = ram_rd_data;
  assign rb_data  = ram_rd_data;

`ifdef NUM_RAM_ARB_STATS_EN
  logic [1:0][15:0] conf_cnt;

  // Count conflict cycles per port, saturating; cleared by reset or a new clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_cnt <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (clear_req)
          conf_cnt[p] <= '0;
        else if (grant_en && (&port_req[p]) && conf_cnt[p] != 16'hFFFF)
          conf_cnt[p] <= conf_cnt[p] + 16'd1;
      end
    end
  end

  assign wr_conflict_cnt = conf_cnt[0];
  assign rd_conflict_cnt = conf_cnt[1];
`endif
endmodule

// File: tb/tb_num_ram_arbiter.sv
// Self-checking bench for num_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_num_ram_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          clear_busy, clear_done;
  logic          wa_req = 1'b0, wb_req = 1'b0, ra_req = 1'b0, rb_req = 1'b0;
  logic [AW-1:0] wa_addr = '0, wb_addr = '0, ra_addr = '0, rb_addr = '0;
  logic [DW-1:0] wa_data = '0, wb_data = '0;
  logic          wa_gnt, wb_gnt, ra_gnt, rb_gnt, ra_valid, rb_valid;
  logic [DW-1:0] ra_data, rb_data;
  logic          ram_clear, ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
`ifdef NUM_RAM_ARB_STATS_EN
  logic [15:0]   wr_conflict_cnt, rd_conflict_cnt;
`endif

  typedef struct {logic side; logic [DW-1:0] data;} rd_exp_t;
  rd_exp_t rd_q[$];
  logic    wr_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  num_ram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done),
    .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_gnt(wa_gnt),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .ra_req(ra_req), .ra_addr(ra_addr), .ra_gnt(ra_gnt), .ra_valid(ra_valid),
    .ra_data(ra_data),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_gnt(rb_gnt), .rb_valid(rb_valid),
    .rb_data(rb_data),
    .ram_clear(ram_clear), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
`ifdef NUM_RAM_ARB_STATS_EN
    .wr_conflict_cnt(wr_conflict_cnt), .rd_conflict_cnt(rd_conflict_cnt),
`endif
    .ram_rd_data(ram_rd_data)
  );

  // RAM model: read-before-write, clear modelled as an instant wipe
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_clear) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic drop_all();
    wa_req = 1'b0; wb_req = 1'b0; ra_req = 1'b0; rb_req = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wa_req = 1'b1; ra_req = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (wa_gnt !== 1'b0 || ra_gnt !== 1'b0 || ram_wr_en !== 1'b0)
      begin n_fail++; $display("FAIL reset_gnt: wa_gnt=%b ra_gnt=%b wr_en=%b expected 0", wa_gnt, ra_gnt, ram_wr_en); end
    n_chk++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0 || ram_clear !== 1'b0 || ra_valid !== 1'b0 || rb_valid !== 1'b0)
      begin n_fail++; $display("FAIL reset_status: busy=%b done=%b clr=%b va=%b vb=%b expected 0", clear_busy, clear_done, ram_clear, ra_valid, rb_valid); end
    drop_all();
    #1;
    n_chk++;
    if (ram_rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", ram_rd_addr); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_single();
    @(negedge clk);
    wa_req = 1'b1; wa_addr = 11'd5; wa_data = 32'h1234;
    #1;
    n_chk++;
    if (wa_gnt !== 1'b1 || wb_gnt !== 1'b0 || ram_wr_en !== 1'b1)
      begin n_fail++; $display("FAIL wr_single_gnt: wa=%b wb=%b en=%b expected 1 0 1", wa_gnt, wb_gnt, ram_wr_en); end
    n_chk++;
    if (ram_wr_addr !== 11'd5 || ram_wr_data !== 32'h1234)
      begin n_fail++; $display("FAIL wr_single_mux: addr=%0d data=%h expected 5 1234", ram_wr_addr, ram_wr_data); end
    @(posedge clk); #1 drop_all();
  endtask

  task automatic test_write_conflict();
    logic exp;
    for (int i = 0; i < 4; i++) wr_q.push_back(i[0]);
    @(negedge clk);
    wa_req = 1'b1; wa_addr = 11'd20; wa_data = 32'hAAAA;
    wb_req = 1'b1; wb_addr = 11'd21; wb_data = 32'hBBBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = wr_q.pop_front();
      n_chk++;
      if ({wb_gnt, wa_gnt} !== (exp ? 2'b10 : 2'b01) || ram_wr_addr !== (exp ? 11'd21 : 11'd20))
        begin n_fail++; $display("FAIL wr_conflict_%0d: gnt(b,a)=%b%b addr=%0d expected side %0d", i, wb_gnt, wa_gnt, ram_wr_addr, exp); end
      @(posedge clk);
      if (i == 3) #1 drop_all();
      @(negedge clk);
    end
`ifdef NUM_RAM_ARB_STATS_EN
    n_chk++;
    if (wr_conflict_cnt !== 16'd4) begin n_fail++; $display("FAIL wr_conflict_cnt: got %0d expected 4", wr_conflict_cnt); end
`endif
  endtask

  task automatic test_read();
    rd_exp_t e;
    ra_req = 1'b1; ra_addr = 11'd5;
    #1;
    n_chk++;
    if (ra_gnt !== 1'b1 || rb_gnt !== 1'b0 || ram_rd_addr !== 11'd5)
      begin n_fail++; $display("FAIL rd_single_gnt: ra=%b rb=%b addr=%0d expected 1 0 5", ra_gnt, rb_gnt, ram_rd_addr); end
    rd_q.push_back('{1'b0, 32'h1234});
    @(posedge clk); #1 drop_all();
    @(negedge clk);
    e = rd_q.pop_front();
    n_chk++;
    if (ra_valid !== 1'b1 || rb_valid !== 1'b0 || ra_data !== e.data)
      begin n_fail++; $display("FAIL rd_single_data: va=%b vb=%b data=%h expected 1 0 %h", ra_valid, rb_valid, ra_data, e.data); end
    ra_req = 1'b1; ra_addr = 11'd20; rb_req = 1'b1; rb_addr = 11'd21;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++;
      if ({rb_gnt, ra_gnt} !== (k[0] ? 2'b10 : 2'b01))
        begin n_fail++; $display("FAIL rd_conflict_gnt_%0d: gnt(b,a)=%b%b expected side %0d", k, rb_gnt, ra_gnt, k); end
      rd_q.push_back('{k[0], k[0] ? 32'hBBBB : 32'hAAAA});
      @(posedge clk);
      if (k == 1) #1 drop_all();
      @(negedge clk);
      e = rd_q.pop_front();
      n_chk++;
      if ({rb_valid, ra_valid} !== (e.side ? 2'b10 : 2'b01) || (e.side ? rb_data : ra_data) !== e.data)
        begin n_fail++; $display("FAIL rd_conflict_data_%0d: valid(b,a)=%b%b data=%h expected side %0d data %h", k, rb_valid, ra_valid, e.side ? rb_data : ra_data, e.side, e.data); end
    end
    @(negedge clk);
    n_chk++;
    if (ra_valid !== 1'b0 || rb_valid !== 1'b0)
      begin n_fail++; $display("FAIL rd_idle_valid: va=%b vb=%b expected 0 0", ra_valid, rb_valid); end
  endtask

  task automatic test_clear();
    int busy = 0, clr = 0, bad = 0;
    rd_exp_t e;
    @(negedge clk);
    clear_req = 1'b1; wa_req = 1'b1; wa_addr = 11'd7; wa_data = 32'h77;
    #1;
    n_chk++;
    if (wa_gnt !== 1'b0) begin n_fail++; $display("FAIL clear_wins: wa_gnt=%b expected 0", wa_gnt); end
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    while (clear_busy === 1'b1 && busy < 3000) begin
      busy++;
      if (ram_clear === 1'b1) clr++;
      if (wa_gnt !== 1'b0 || clear_done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (busy != DEPTH + 1) begin n_fail++; $display("FAIL clear_busy_len: got %0d expected %0d", busy, DEPTH + 1); end
    n_chk++;
    if (clr != 1 || bad != 0) begin n_fail++; $display("FAIL clear_sweep: ram_clear cycles=%0d bad cycles=%0d expected 1 0", clr, bad); end
    n_chk++;
    if (clear_done !== 1'b1 || wa_gnt !== 1'b1)
      begin n_fail++; $display("FAIL clear_end: done=%b wa_gnt=%b expected 1 1", clear_done, wa_gnt); end
    @(posedge clk); #1 drop_all();
    @(negedge clk);
    n_chk++;
    if (clear_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_pulse: got %b expected 0", clear_done); end
    ra_req = 1'b1; ra_addr = 11'd5;
    rd_q.push_back('{1'b0, 32'h0});
    @(posedge clk); #1 ra_addr = 11'd7;
    rd_q.push_back('{1'b0, 32'h77});
    @(negedge clk);
    e = rd_q.pop_front();
    n_chk++;
    if (ra_valid !== 1'b1 || ra_data !== e.data) begin n_fail++; $display("FAIL clear_rd5: valid=%b data=%h expected 1 %h", ra_valid, ra_data, e.data); end
    @(posedge clk); #1 drop_all();
    @(negedge clk);
    e = rd_q.pop_front();
    n_chk++;
    if (ra_valid !== 1'b1 || ra_data !== e.data) begin n_fail++; $display("FAIL clear_rd7: valid=%b data=%h expected 1 %h", ra_valid, ra_data, e.data); end
  endtask

  task automatic test_restart();
    int early = 0, n = 0;
    @(negedge clk) clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (clear_done !== 1'b0) early++;
    end
    @(negedge clk) clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    n = 1;
    n_chk++;
    if (ram_clear !== 1'b1 || clear_busy !== 1'b1)
      begin n_fail++; $display("FAIL restart_repulse: ram_clear=%b busy=%b expected 1 1", ram_clear, clear_busy); end
    while (clear_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != DEPTH + 2 || early != 0)
      begin n_fail++; $display("FAIL restart_done: done after %0d cycles, early pulses %0d, expected %0d 0", n, early, DEPTH + 2); end
    @(negedge clk);
    n_chk++;
    if (clear_done !== 1'b0 || clear_busy !== 1'b0)
      begin n_fail++; $display("FAIL restart_single: done=%b busy=%b expected 0 0", clear_done, clear_busy); end
  endtask

  task automatic test_reset_mid();
    // one conflict on each port moves both pointers to B
    wa_req = 1'b1; wb_req = 1'b1; ra_req = 1'b1; rb_req = 1'b1;
    #1;
    n_chk++;
    if (wa_gnt !== 1'b1 || ra_gnt !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ptr: wa=%b ra=%b expected 1 1", wa_gnt, ra_gnt); end
    @(posedge clk); #1 drop_all();
    @(negedge clk) clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    repeat (50) @(negedge clk);
    wa_req = 1'b1; ra_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (clear_busy !== 1'b0 || ram_clear !== 1'b0 || clear_done !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_fsm: busy=%b clr=%b done=%b expected 0", clear_busy, ram_clear, clear_done); end
    n_chk++;
    if (wa_gnt !== 1'b0 || ra_gnt !== 1'b0 || ra_valid !== 1'b0 || rb_valid !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_gnt: wa=%b ra=%b va=%b vb=%b expected 0", wa_gnt, ra_gnt, ra_valid, rb_valid); end
    drop_all();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    wa_req = 1'b1; wb_req = 1'b1; ra_req = 1'b1; rb_req = 1'b1;
    #1;
    n_chk++;
    if ({wb_gnt, wa_gnt} !== 2'b01 || {rb_gnt, ra_gnt} !== 2'b01)
      begin n_fail++; $display("FAIL mid_reset_ptr: wgnt(b,a)=%b%b rgnt(b,a)=%b%b expected 01 01", wb_gnt, wa_gnt, rb_gnt, ra_gnt); end
    @(posedge clk); #1 drop_all();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_conflict();
    test_read();
    test_clear();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
